serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks the operands LSB first and
// presents sum, carry-out and signed overflow once the last bit has been added.

module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_full;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             armed;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .A   (a_sh[0]),
    .B   (b_sh[0]),
    .Cin (carry),
    .Sum (fa_sum),
    .Cout(fa_cout)
  );

  // The newest sum bit enters at the MSB; after WIDTH shifts the word is aligned.
  assign res_full = {fa_sum, res_sh};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // armed stays low for the first edge after reset so a start coinciding with
  // reset release is never taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (start && armed) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            res_sh <= '0;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_full[WIDTH-1:1];
          carry  <= fa_cout;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB at this point
            sum   <= res_full;
            cout  <= fa_cout;
            ovf   <= carry ^ fa_cout;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
